// File: rtl/dcache_meta_array.sv
// dcache_meta_array: 64-set x 4-way dcache tag array with post-reset invalidation sweep.
// Optional per-entry even parity when DCACHE_META_PARITY_EN is defined.
module dcache_meta_array #(
    parameter int NSETS = 64,
    parameter int NWAYS = 4,
    parameter int META_W = 22,
    parameter logic [META_W-1:0] RST_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_in_ready,
    input  logic                     io_in_valid,
    input  logic                     io_in_bits_write,
    input  logic [$clog2(NSETS)-1:0] io_in_bits_idx,
    input  logic [NWAYS-1:0]         io_in_bits_way_en,
    input  logic [META_W-1:0]        io_in_bits_data,
    output logic                     io_resp_valid,
    output logic [META_W-1:0]        io_resp_0_data,
    output logic [META_W-1:0]        io_resp_1_data,
    output logic [META_W-1:0]        io_resp_2_data,
    output logic [META_W-1:0]        io_resp_3_data,
    output logic [NWAYS-1:0]         io_resp_err
);
    localparam int IW = $clog2(NSETS);
    localparam logic SWEEP = 1'b0;
    localparam logic RUN = 1'b1;

    logic              state;
    logic [IW-1:0]     rst_cnt;
    logic [META_W-1:0] mem [NSETS][NWAYS];
    logic [META_W-1:0] resp_q [NWAYS];
    logic              rd_fire;
    logic              wr_fire;

    // ready is a pure function of state so the arbiter sees no valid->ready path
    assign io_in_ready = state == RUN;
    assign rd_fire = io_in_valid & io_in_ready & ~io_in_bits_write;
    assign wr_fire = io_in_valid & io_in_ready & io_in_bits_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SWEEP;
            rst_cnt <= '0;
        end else if (state == SWEEP) begin
            rst_cnt <= rst_cnt + 1'b1;
            if (&rst_cnt) state <= RUN;
        end
    end

`ifdef DCACHE_META_PARITY_EN
    logic             par_mem [NSETS][NWAYS];
    logic [NWAYS-1:0] err_q;
    assign io_resp_err = err_q;
`else
    assign io_resp_err = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (state == SWEEP) begin
                    mem[rst_cnt][w] <= RST_VAL;
`ifdef DCACHE_META_PARITY_EN
                    par_mem[rst_cnt][w] <= ^RST_VAL;
`endif
                end else if (wr_fire && io_in_bits_way_en[w]) begin
                    mem[io_in_bits_idx][w] <= io_in_bits_data;
`ifdef DCACHE_META_PARITY_EN
                    par_mem[io_in_bits_idx][w] <= ^io_in_bits_data;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_resp_valid <= 1'b0;
            for (int w = 0; w < NWAYS; w++) resp_q[w] <= '0;
`ifdef DCACHE_META_PARITY_EN
            err_q <= '0;
`endif
        end else begin
            io_resp_valid <= rd_fire;
            if (rd_fire) begin
                for (int w = 0; w < NWAYS; w++) begin
                    resp_q[w] <= mem[io_in_bits_idx][w];
`ifdef DCACHE_META_PARITY_EN
                    err_q[w] <= par_mem[io_in_bits_idx][w] ^ (^mem[io_in_bits_idx][w]);
`endif
                end
            end
        end
    end

    assign io_resp_0_data = resp_q[0];
    assign io_resp_1_data = resp_q[1];
    assign io_resp_2_data = resp_q[2];
    assign io_resp_3_data = resp_q[3];
endmodule

// File: tb/tb_dcache_meta_array.sv
// tb_dcache_meta_array: directed bench for the dcache metadata array (sweep, masked write,
// back-to-back reads, mid-run reset, ignored sweep input, parity).
module tb_dcache_meta_array;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_ready;
    logic        io_in_valid = 1'b0;
    logic        io_in_bits_write = 1'b0;
    logic [5:0]  io_in_bits_idx = '0;
    logic [3:0]  io_in_bits_way_en = '0;
    logic [21:0] io_in_bits_data = '0;
    logic        io_resp_valid;
    logic [21:0] io_resp_0_data, io_resp_1_data, io_resp_2_data, io_resp_3_data;
    logic [3:0]  io_resp_err;
    logic [21:0] rd [4];
    int vecs = 0;
    int errs = 0;

    dcache_meta_array dut (
        .clock(clock), .reset(reset), .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
        .io_in_bits_write(io_in_bits_write), .io_in_bits_idx(io_in_bits_idx),
        .io_in_bits_way_en(io_in_bits_way_en), .io_in_bits_data(io_in_bits_data),
        .io_resp_valid(io_resp_valid), .io_resp_0_data(io_resp_0_data),
        .io_resp_1_data(io_resp_1_data), .io_resp_2_data(io_resp_2_data),
        .io_resp_3_data(io_resp_3_data), .io_resp_err(io_resp_err)
    );

    always #5 clock = ~clock;
    assign rd = '{io_resp_0_data, io_resp_1_data, io_resp_2_data, io_resp_3_data};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [5:0] idx, input logic [3:0] en, input logic [21:0] d);
        io_in_valid = 1'b1;
        io_in_bits_write = wr;
        io_in_bits_idx = idx;
        io_in_bits_way_en = en;
        io_in_bits_data = d;
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vecs++;
        if (io_in_ready !== 1'b0 || io_resp_valid !== 1'b0 || io_resp_err !== 4'h0) begin
            errs++;
            $display("FAIL rst_outputs ready=%b resp_valid=%b err=%h want 0/0/0", io_in_ready, io_resp_valid, io_resp_err);
        end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h0) begin errs++; $display("FAIL rst_data way%0d got %h want 0", w, rd[w]); end
        end
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            vecs++;
            if (io_in_ready !== (i == 63)) begin
                errs++;
                $display("FAIL sweep_ready edge%0d got %b want %b", i + 1, io_in_ready, i == 63);
            end
        end
        foreach (rd[k]) begin end
        for (int j = 0; j < 3; j++) begin
            logic [5:0] idx;
            idx = (j == 0) ? 6'h00 : (j == 1) ? 6'h15 : 6'h3F;
            issue(1'b0, idx, 4'h0, 22'h0);
            vecs++;
            if (io_resp_valid !== 1'b1 || io_resp_err !== 4'h0) begin
                errs++;
                $display("FAIL rst_read idx%h valid=%b err=%h want 1/0", idx, io_resp_valid, io_resp_err);
            end
            for (int w = 0; w < 4; w++) begin
                vecs++;
                if (rd[w] !== 22'h0) begin errs++; $display("FAIL rst_read idx%h way%0d got %h want 0", idx, w, rd[w]); end
            end
        end
    endtask

    task automatic test_masked_write();
        logic [21:0] exp [4];
        exp = '{22'h3ABCDE, 22'h0, 22'h3ABCDE, 22'h0};
        issue(1'b1, 6'h2A, 4'b0101, 22'h3ABCDE);
        vecs++;
        if (io_resp_valid !== 1'b0) begin errs++; $display("FAIL mw_write_resp got %b want 0", io_resp_valid); end
        issue(1'b0, 6'h2A, 4'h0, 22'h0);
        vecs++;
        if (io_resp_valid !== 1'b1) begin errs++; $display("FAIL mw_valid got %b want 1", io_resp_valid); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== exp[w]) begin errs++; $display("FAIL mw_data way%0d got %h want %h", w, rd[w], exp[w]); end
        end
        tick();
        vecs++;
        if (io_resp_valid !== 1'b0) begin errs++; $display("FAIL mw_pulse got %b want 0", io_resp_valid); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== exp[w]) begin errs++; $display("FAIL mw_hold way%0d got %h want %h", w, rd[w], exp[w]); end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 6'd5, 4'hF, 22'h000123);
        io_in_valid = 1'b1;
        io_in_bits_write = 1'b0;
        io_in_bits_idx = 6'd5;
        tick();
        io_in_bits_idx = 6'd6;
        vecs++;
        if (io_resp_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid0 got %b want 1", io_resp_valid); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h000123) begin errs++; $display("FAIL b2b_idx5 way%0d got %h want 000123", w, rd[w]); end
        end
        tick();
        io_in_valid = 1'b0;
        vecs++;
        if (io_resp_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid1 got %b want 1", io_resp_valid); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h0) begin errs++; $display("FAIL b2b_idx6 way%0d got %h want 0", w, rd[w]); end
        end
        tick();
        vecs++;
        if (io_resp_valid !== 1'b0) begin errs++; $display("FAIL b2b_fall got %b want 0", io_resp_valid); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h0) begin errs++; $display("FAIL b2b_hold way%0d got %h want 0", w, rd[w]); end
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 6'd63, 4'hF, 22'h1FFFFF);
        reset = 1'b1;
        issue(1'b0, 6'd63, 4'h0, 22'h0);
        vecs++;
        if (io_resp_valid !== 1'b0) begin errs++; $display("FAIL mid_drop got %b want 0", io_resp_valid); end
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            vecs++;
            if (io_in_ready !== (i == 63)) begin
                errs++;
                $display("FAIL mid_ready edge%0d got %b want %b", i + 1, io_in_ready, i == 63);
            end
        end
        issue(1'b0, 6'd63, 4'h0, 22'h0);
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h0) begin errs++; $display("FAIL mid_idx63 way%0d got %h want 0", w, rd[w]); end
        end
    endtask

    task automatic test_sweep_ignore();
        reset = 1'b1;
        io_in_valid = 1'b1;
        io_in_bits_write = 1'b1;
        io_in_bits_idx = 6'd0;
        io_in_bits_way_en = 4'hF;
        io_in_bits_data = 22'h3FFFFF;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            vecs++;
            if (io_in_ready !== (i == 63)) begin
                errs++;
                $display("FAIL ign_ready edge%0d got %b want %b", i + 1, io_in_ready, i == 63);
            end
        end
        io_in_valid = 1'b0;
        issue(1'b0, 6'd0, 4'h0, 22'h0);
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== 22'h0) begin errs++; $display("FAIL ign_idx0 way%0d got %h want 0", w, rd[w]); end
        end
    endtask

    task automatic test_parity();
        logic [21:0] exp [4];
        logic [3:0]  exp_err;
        issue(1'b1, 6'd9, 4'hF, 22'h000001);
`ifdef DCACHE_META_PARITY_EN
        dut.mem[9][2][0] = ~dut.mem[9][2][0];
        exp = '{22'h1, 22'h1, 22'h0, 22'h1};
        exp_err = 4'b0100;
`else
        exp = '{22'h1, 22'h1, 22'h1, 22'h1};
        exp_err = 4'b0000;
`endif
        issue(1'b0, 6'd9, 4'h0, 22'h0);
        vecs++;
        if (io_resp_err !== exp_err) begin errs++; $display("FAIL par_err got %b want %b", io_resp_err, exp_err); end
        for (int w = 0; w < 4; w++) begin
            vecs++;
            if (rd[w] !== exp[w]) begin errs++; $display("FAIL par_data way%0d got %h want %h", w, rd[w], exp[w]); end
        end
        tick();
        vecs++;
        if (io_resp_err !== exp_err) begin errs++; $display("FAIL par_hold got %b want %b", io_resp_err, exp_err); end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_reset_mid();
        test_sweep_ignore();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dcache_meta_array.md
# dcache_meta_array

Single-port L1 data-cache metadata (tag) array for the 64-set, 4-way dcache. It sits directly downstream of the metadata request arbiter and consumes its merged output stream: one read or one masked write per cycle. Reads return all four ways one cycle later. After reset it sweeps every set to the invalid state before accepting requests.

## Interface
Parameters:
- NSETS, 64, number of sets; power of two; index width is log2(NSETS) = 6.
- NWAYS, 4, number of ways; equals the width of `io_in_bits_way_en`.
- META_W, 22, metadata width per way: {coh[1:0], tag[19:0]}.
- RST_VAL, 22'h0, value written by the reset sweep (coh = 0, invalid).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_ready  out  1  array can accept a request this cycle.
- io_in_valid  in  1  request present; driven from the arbiter's out_valid.
- io_in_bits_write  in  1  1 = write, 0 = read.
- io_in_bits_idx  in  6  set index.
- io_in_bits_way_en  in  4  per-way write mask; ignored on reads.
- io_in_bits_data  in  22  write data, applied to every enabled way.
- io_resp_valid  out  1  read data valid; one-cycle pulse.
- io_resp_0_data … io_resp_3_data  out  22 each  metadata of ways 0..3 for the last accepted read.
- io_resp_err  out  4  per-way parity error flags for the last read; tied 0 unless DCACHE_META_PARITY_EN is defined.

## Operation
- Storage: NSETS × NWAYS entries of META_W bits, plus 1 parity bit per entry when parity is enabled.
- A request is accepted ("fire") when io_in_valid & io_in_ready.
- State machine, 2 states:
  - SWEEP: entered while reset is high. rst_cnt is cleared to 0 and io_in_ready = 0.
  - RUN: io_in_ready = 1.
- SWEEP behaviour, on each edge with reset low:
  - Write RST_VAL (and its parity) to all ways of set rst_cnt, then increment rst_cnt.
  - On the edge that writes set NSETS-1, go to RUN.
  - io_in_valid is ignored in SWEEP. Nothing is accepted or lost, because ready is low and the arbiter holds its request.
- Write fire: for each w with way_en[w] = 1, entry[idx][w] ← data. Ways with way_en[w] = 0 are untouched. way_en = 0 is a legal no-op.
- Read fire: all NWAYS entries of set idx are latched into the response registers.
- Write fire never produces io_resp_valid.
- Response registers hold their value until the next read fire. Only io_resp_valid pulses.
- Reset values:
  - io_in_ready = 0
  - io_resp_valid = 0
  - io_resp_*_data = 0
  - io_resp_err = 0
  - rst_cnt = 0
- Reset asserted mid-sweep or mid-run: the sweep restarts at set 0, and any in-flight read response is dropped (resp_valid = 0 on the next cycle).

## Timing
- Sweep length: io_in_ready rises exactly NSETS = 64 rising edges after the first edge sampled with reset low.
- Read latency 1: read fire at edge N gives io_resp_valid = 1 and data valid during cycle N+1.
- Back-to-back reads are accepted every cycle, with one response per cycle.
- Write followed by read of the same set on the next cycle returns the new data. The write updates storage at edge N; the read latches at edge N+1.
- io_in_ready depends only on state, with no combinational path from io_in_valid. This avoids a loop through the arbiter's ready logic.
- Throughput: 1 request per cycle in RUN.

## Configuration
- Macro: DCACHE_META_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit, the XOR of its 22 data bits, written alongside every data write, including the sweep.
  - On read, io_resp_err[w] = stored parity ^ recomputed parity of way w, registered with the data and held with it.
  - Errors are reported only. Data is returned unchanged, and an error does not affect io_in_ready.
- Undefined:
  - No parity storage or logic.
  - io_resp_err is constant 4'h0.
  - Ports and timing are otherwise identical.

## Test plan
- Reset sweep: hold reset 3 cycles, then release → io_in_ready = 0 for 64 cycles, then 1. Reading idx 0x00, 0x15 and 0x3F returns all ways = 0 with io_resp_err = 0.
- Masked write: write idx 0x2A, way_en 4'b0101, data 22'h3ABCDE, then read idx 0x2A → way0 = way2 = 22'h3ABCDE, way1 = way3 = 0, resp_valid pulses once at read+1.
- Back-to-back access: write idx 5 data 22'h000123 all ways at cycle N; read idx 5 at N+1 and read idx 6 at N+2 → resp at N+2 is 22'h000123 ×4, resp at N+3 is 0 ×4. The data holds after resp_valid falls.
- Reset mid-operation: after sweep, write idx 63 = 22'h1FFFFF on all ways; assert reset at sweep cycle 10 of a new sweep; release → ready low for a full 64 cycles, and reading idx 63 returns 0.
- Ignored input in SWEEP: drive io_in_valid = 1 with write idx 0 data 22'h3FFFFF throughout the sweep → no write occurs, and idx 0 reads 0 after ready rises.
- Parity (DCACHE_META_PARITY_EN): write idx 9 data 22'h000001 on all ways; backdoor-flip bit 0 of way 2 storage; read idx 9 → io_resp_err = 4'b0100 and io_resp_2_data = 22'h000000. Without the macro, io_resp_err = 0.
